card_layer_compositor: RTL
==========================

Name: card_layer_compositor

Overview:
- Sits between the VGA timing generator and the background generator on one side, and the VGA output stage on the other.
- Consumes the pixel counters and the background RGB. Overlays up to N_SLOTS card sprites fetched from an external synchronous sprite ROM. Produces the composited pixel for the VGA output stage.
- Game logic programs card slots through a valid/ready port. Slot writes land in shadow registers and commit at the frame boundary, so no frame ever tears.

Parameters:
- N_SLOTS, 8, number of card slots; a higher index draws on top.
- CARD_W, 64, sprite width in pixels.
- CARD_H, 96, sprite height in pixels.
- N_CARDS, 54, number of distinct card faces in the ROM.
- ROM_AW, 19, ROM address width; must satisfy 2^ROM_AW >= N_CARDS*CARD_W*CARD_H.
- H_ACTIVE, 640, visible width.
- V_ACTIVE, 480, visible height.
- KEY_COLOR, 24'hFF00FF, transparent sprite colour.

Ports:
- i_clk_25M  in  1  pixel clock.
- i_rst  in  1  synchronous, active-high reset.
- i_x_cnt  in  10  current pixel column.
- i_y_cnt  in  10  current pixel row.
- i_bg_r, i_bg_g, i_bg_b  in  8 each  background colour for (i_x_cnt, i_y_cnt).
- i_slot_wr_valid  in  1  slot write request.
- o_slot_wr_ready  out  1  write accepted when valid && ready.
- i_slot_idx  in  $clog2(N_SLOTS)  target slot.
- i_slot_en  in  1  slot visible.
- i_slot_x, i_slot_y  in  10 each  top-left corner of the card.
- i_slot_card  in  6  card face id.
- o_rom_addr  out  ROM_AW  sprite ROM address (registered).
- i_rom_data  in  24  RGB888; valid exactly one cycle after o_rom_addr.
- o_r, o_g, o_b  out  8 each  composited pixel.
- o_x_cnt, o_y_cnt  out  10 each  counters aligned with o_r/o_g/o_b.

Behaviour:
- Clock and reset:
  - Single clock i_clk_25M.
  - Reset is synchronous and active-high on i_rst.
  - Reset clears all shadow and active slot entries (en=0, x=y=card=0).
  - Reset drives all outputs to 0, o_rom_addr=0 and o_slot_wr_ready=0.
  - o_slot_wr_ready rises in the first cycle after i_rst deasserts.
- Latency: fixed 3 cycles from inputs to outputs.
  - T: hit test.
  - T+1: o_rom_addr registered.
  - T+2: i_rom_data valid; compositing.
  - T+3: o_r/o_g/o_b and o_x_cnt/o_y_cnt valid.
  - Background RGB and counters travel through a matching 3-deep delay line.
- Hit test: slot s hits when all of the following hold:
  - en=1 and card < N_CARDS;
  - x >= sx and x < sx+CARD_W;
  - y >= sy and y < sy+CARD_H.
  - Sums are computed in 11 bits, so a card near coordinate 1023 does not wrap.
  - Card id >= N_CARDS never hits.
  - The highest-index hitting slot wins.
- Address: card*CARD_W*CARD_H + (y-sy)*CARD_W + (x-sx), truncated to ROM_AW. o_rom_addr holds its previous value when there is no hit.
- Composite, at T+2:
  - Output = background when there is no hit, or when i_rom_data == KEY_COLOR.
  - Output = i_rom_data otherwise.
  - Output = 0 when the delayed x >= H_ACTIVE or y >= V_ACTIVE.
  - Hits only test the winning slot. A lower slot beneath a transparent pixel is not shown; background shows through.
- Slot writes:
  - An accepted write updates only the shadow entry i_slot_idx.
  - Several writes to the same slot before a commit: the last one wins.
- Commit:
  - Triggered in the single cycle where i_x_cnt==0 and i_y_cnt==V_ACTIVE (first blanking line).
  - Copies all shadow entries to active.
  - o_slot_wr_ready=0 in that cycle only; a write presented then stalls and is accepted the next cycle, landing after the commit.
- Mid-frame: active entries never change except at commit.
- Reset mid-frame: pipeline contents are discarded and outputs go to 0 on the reset cycle. There is no partial commit.

Decomposition:
- Package display_pkg holds:
  - H_ACTIVE, V_ACTIVE, CARD_W, CARD_H, N_CARDS and KEY_COLOR;
  - rgb_t (packed r/g/b, 8 bits each);
  - slot_t (en, x[9:0], y[9:0], card[5:0]).
- Sub-module slot_hit_select: purely combinational. Takes the active slot_t array and x/y; returns hit, winning index, row and col.
- card_layer_compositor holds the registers, the commit logic, the pipeline and the compositing.

Test Plan:
- Reset, then no writes; drive bg=(10,20,30) at x=5,y=5 -> three cycles later o_r/g/b=(10,20,30), o_x_cnt=5, o_y_cnt=5.
- Write slot 0 (en=1, x=100, y=50, card=3), then run to the commit (x=0, y=480). Next frame at x=100,y=50: o_rom_addr=3*6144=18432. ROM returns 24'h123456 -> output (0x12,0x34,0x56) at T+3. At x=164 (outside): background.
- Slots 0 and 5 overlap at pixel (120,60) -> the address uses slot 5's card. ROM returns KEY_COLOR -> output = background.
- Write presented in the commit cycle -> o_slot_wr_ready=0 that cycle, accepted next cycle. The new value appears only after the following commit, one frame later.
- Slot with x=1000, y=470, card=60 (>= N_CARDS) -> never hits. Slot with x=1000 and a valid card -> no hit at x=0..39 (no wrap).
- Assert i_rst mid-frame while a card is visible -> outputs are 0 on the reset cycle, all slots are disabled, and ready=0 during reset.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display geometry, colour and card-slot types
// for the card layer compositor.
package display_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int CARD_W   = 64;
  localparam int CARD_H   = 96;
  localparam int N_CARDS  = 54;

  localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] card;
  } slot_t;

endpackage

// File: rtl/card_layer_compositor_if.sv
// Slot-programming port: game logic (master) writes
// card slots into the compositor (slave).
interface card_layer_compositor_if #(
  parameter int N_SLOTS = 8
);

  logic                       i_slot_wr_valid;
  logic                       o_slot_wr_ready;
  logic [$clog2(N_SLOTS)-1:0] i_slot_idx;
  logic                       i_slot_en;
  logic [9:0]                 i_slot_x;
  logic [9:0]                 i_slot_y;
  logic [5:0]                 i_slot_card;

  modport master (
    output i_slot_wr_valid,
    output i_slot_idx,
    output i_slot_en,
    output i_slot_x,
    output i_slot_y,
    output i_slot_card,
    input  o_slot_wr_ready
  );

  modport slave (
    input  i_slot_wr_valid,
    input  i_slot_idx,
    input  i_slot_en,
    input  i_slot_x,
    input  i_slot_y,
    input  i_slot_card,
    output o_slot_wr_ready
  );

endinterface

// File: rtl/card_layer_compositor_slot_hit_select.sv
// Combinational hit test over all active slots;
// the highest-index hitting slot wins.
import display_pkg::*;

module slot_hit_select #(
  parameter int N_SLOTS = 8
) (
  input  slot_t                      slots [N_SLOTS],
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  output logic                       hit,
  output logic [$clog2(N_SLOTS)-1:0] idx,
  output logic [$clog2(CARD_H)-1:0]  row,
  output logic [$clog2(CARD_W)-1:0]  col
);

  localparam int IW = $clog2(N_SLOTS);
  localparam int RW = $clog2(CARD_H);
  localparam int CW = $clog2(CARD_W);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        in_x;
  logic        in_y;
  logic        ok;

  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    row   = '0;
    col   = '0;
    x_end = '0;
    y_end = '0;
    in_x  = 1'b0;
    in_y  = 1'b0;
    ok    = 1'b0;
    for (int s = 0; s < N_SLOTS; s++) begin
      // 11-bit ends keep cards near 1023 from wrapping to 0
      x_end = {1'b0, slots[s].x} + 11'(CARD_W);
      y_end = {1'b0, slots[s].y} + 11'(CARD_H);
      in_x  = (x >= slots[s].x) && ({1'b0, x} < x_end);
      in_y  = (y >= slots[s].y) && ({1'b0, y} < y_end);
      ok    = slots[s].en &&
              (32'(slots[s].card) < N_CARDS);
      if (ok && in_x && in_y) begin
        hit = 1'b1;
        idx = IW'(s);
        row = RW'(y - slots[s].y);
        col = CW'(x - slots[s].x);
      end
    end
  end

endmodule

// File: rtl/card_layer_compositor.sv
// Card sprite overlay: shadow/active slot tables, hit test,
// ROM fetch and 3-cycle compositing pipeline.
import display_pkg::*;

module card_layer_compositor #(
  parameter int N_SLOTS = 8,
  parameter int ROM_AW  = 19
) (
  input  logic                  i_clk_25M,
  input  logic                  i_rst,
  input  logic [9:0]            i_x_cnt,
  input  logic [9:0]            i_y_cnt,
  input  logic [7:0]            i_bg_r,
  input  logic [7:0]            i_bg_g,
  input  logic [7:0]            i_bg_b,
  card_layer_compositor_if.slave slot_wr,
  output logic [ROM_AW-1:0]     o_rom_addr,
  input  logic [23:0]           i_rom_data,
  output logic [7:0]            o_r,
  output logic [7:0]            o_g,
  output logic [7:0]            o_b,
  output logic [9:0]            o_x_cnt,
  output logic [9:0]            o_y_cnt
);

  localparam int IW = $clog2(N_SLOTS);
  localparam int RW = $clog2(CARD_H);
  localparam int CW = $clog2(CARD_W);

  typedef struct packed {
    rgb_t       bg;
    logic [9:0] x;
    logic [9:0] y;
    logic       hit;
  } pix_t;

  slot_t shadow [N_SLOTS];
  slot_t active [N_SLOTS];

  logic          rdy_q;
  logic          commit;
  logic          wr_fire;
  logic          hit;
  logic [IW-1:0] win;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [31:0]   addr;
  pix_t          s1;
  pix_t          s2;
  rgb_t          mix;

  assign commit = (i_x_cnt == 10'd0) &&
                  (32'(i_y_cnt) == V_ACTIVE);

  assign slot_wr.o_slot_wr_ready = rdy_q && !commit && !i_rst;

  assign wr_fire = slot_wr.i_slot_wr_valid &&
                   slot_wr.o_slot_wr_ready;

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      rdy_q <= 1'b0;
      for (int s = 0; s < N_SLOTS; s++) begin
        shadow[s] <= '0;
        active[s] <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (wr_fire) begin
        shadow[slot_wr.i_slot_idx] <= '{
          en:   slot_wr.i_slot_en,
          x:    slot_wr.i_slot_x,
          y:    slot_wr.i_slot_y,
          card: slot_wr.i_slot_card
        };
      end
      // writes stall during commit, so shadow is stable here
      if (commit) begin
        for (int s = 0; s < N_SLOTS; s++) begin
          active[s] <= shadow[s];
        end
      end
    end
  end

  slot_hit_select #(
    .N_SLOTS (N_SLOTS)
  ) u_hit (
    .slots (active),
    .x     (i_x_cnt),
    .y     (i_y_cnt),
    .hit   (hit),
    .idx   (win),
    .row   (row),
    .col   (col)
  );

  assign addr = 32'(active[win].card) * 32'(CARD_W * CARD_H)
              + 32'(row) * 32'(CARD_W)
              + 32'(col);

  always_comb begin
    mix = s2.bg;
    if (s2.hit && (i_rom_data != KEY_COLOR)) begin
      mix = i_rom_data;
    end
    if ((32'(s2.x) >= H_ACTIVE) || (32'(s2.y) >= V_ACTIVE)) begin
      mix = '0;
    end
  end

  always_ff @(posedge i_clk_25M) begin
    if (i_rst) begin
      s1         <= '0;
      s2         <= '0;
      o_rom_addr <= '0;
      o_r        <= '0;
      o_g        <= '0;
      o_b        <= '0;
      o_x_cnt    <= '0;
      o_y_cnt    <= '0;
    end else begin
      s1 <= '{
        bg:  '{r: i_bg_r, g: i_bg_g, b: i_bg_b},
        x:   i_x_cnt,
        y:   i_y_cnt,
        hit: hit
      };
      s2 <= s1;
      if (hit) begin
        o_rom_addr <= addr[ROM_AW-1:0];
      end
      o_r     <= mix.r;
      o_g     <= mix.g;
      o_b     <= mix.b;
      o_x_cnt <= s2.x;
      o_y_cnt <= s2.y;
    end
  end

endmodule
